// File: rtl/knn_pkg.sv
// knn_pkg: shared KNN datapath defaults and training-fetch state encoding
package knn_pkg;
  localparam int DEF_M = 2;
  localparam int DEF_N = 3;
  localparam int DEF_W = 16;
  localparam int DEF_TYPE_W = 3;
  localparam int DEF_L = 6;
  localparam int DEF_NUM_SAMPLES = 1 << DEF_L;
  localparam int SAMPLE_WORDS = DEF_M * DEF_N + 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, DRAIN} fetch_state_t;
endpackage

// File: rtl/training_data_fetcher.sv
// training_data_fetcher: word-serial fetch of one training sample per request into a packed vector
module training_data_fetcher
  import knn_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  parameter int TYPE_W = DEF_TYPE_W,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int ADDR_W = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_request,
  input  logic                restart,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [W-1:0]        mem_rd_data,
  input  logic                mem_rd_valid,
  output logic [W*M*N-1:0]    training_data,
  output logic [TYPE_W-1:0]   training_data_type,
  output logic                read_done,
  output logic                last_sample,
  output logic                busy
);
  localparam int FW = M * N;
  localparam int SCW = NUM_SAMPLES > 1 ? $clog2(NUM_SAMPLES) : 1;
  localparam int WCW = $clog2(FW + 1);
  localparam logic [SCW-1:0] LAST = SCW'(NUM_SAMPLES - 1);
  localparam logic [WCW-1:0] TW = WCW'(FW);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  fetch_state_t state, state_nxt;
  logic [SCW-1:0] sample_cnt;
  logic [WCW-1:0] word_cnt;
  logic [ADDR_W-1:0] addr;
  logic pending, req_q, present;
  logic [FW*W-1:0] shadow, data_q;
  logic [TYPE_W-1:0] shadow_type, type_q;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (data_request || pending) ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = mem_rd_valid ? ((word_cnt == TW) ? PRESENT : ISSUE) : WAIT;
      PRESENT: state_nxt = IDLE;
      DRAIN:   state_nxt = mem_rd_valid ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
    // a read still outstanding must be drained; one returning this cycle needs no drain
    if (restart)
      state_nxt = (state == ISSUE || ((state == WAIT || state == DRAIN) && !mem_rd_valid)) ? DRAIN : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // outputs show the shadow copy during PRESENT and the held copy otherwise
  assign present = state == PRESENT && !restart;
  assign read_done = present;
  assign last_sample = present && sample_cnt == LAST;
  assign busy = state != IDLE;
  assign mem_rd_en = state == ISSUE;
  assign mem_addr = addr;
  assign training_data = present ? shadow : data_q;
  assign training_data_type = present ? shadow_type : type_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      word_cnt <= '0;
      addr <= BASE;
      pending <= 1'b0;
      req_q <= 1'b0;
      shadow <= '0;
      shadow_type <= '0;
      data_q <= '0;
      type_q <= '0;
    end else begin
      req_q <= data_request;
      if (restart) begin
        sample_cnt <= '0;
        word_cnt <= '0;
        addr <= BASE;
        pending <= 1'b0;
      end else begin
        if (state == IDLE) pending <= 1'b0;
        else if (data_request && !req_q) pending <= 1'b1;
        if (state == WAIT && mem_rd_valid) begin
          if (word_cnt == TW) shadow_type <= mem_rd_data[TYPE_W-1:0];
          else begin
            shadow[int'(word_cnt)*W +: W] <= mem_rd_data;
            addr <= addr + ADDR_W'(1);
            word_cnt <= word_cnt + WCW'(1);
          end
        end
        if (state == PRESENT) begin
          data_q <= shadow;
          type_q <= shadow_type;
          word_cnt <= '0;
          sample_cnt <= (sample_cnt == LAST) ? '0 : sample_cnt + SCW'(1);
          addr <= (sample_cnt == LAST) ? BASE : addr + ADDR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_training_data_fetcher.sv
// tb_training_data_fetcher: directed scoreboard bench with a variable-latency memory model
module tb_training_data_fetcher;
  logic clk = 0, rst = 1, data_request = 0, restart = 0;
  logic mem_rd_en, mem_rd_valid = 0, read_done, last_sample, busy;
  logic [9:0] mem_addr, pa;
  logic [15:0] mem_rd_data = 0;
  logic [95:0] training_data, held;
  logic [2:0] training_data_type;
  int n_cmp = 0, n_err = 0, n_done = 0, n_stray = 0, nxt_s = 0, lat_sel = 1, cnt = 0, rnd = 2, lat_use, saved_done;
  typedef struct {logic [95:0] d; logic [2:0] t; logic l;} exp_t;
  exp_t q[$];

  training_data_fetcher dut (
    .clk(clk), .rst(rst), .data_request(data_request), .restart(restart),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .training_data(training_data),
    .training_data_type(training_data_type), .read_done(read_done),
    .last_sample(last_sample), .busy(busy)
  );

  always #5 clk = ~clk;

  assign lat_use = lat_sel == 0 ? rnd : lat_sel;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0;
      mem_rd_valid <= 0;
    end else begin
      mem_rd_valid <= 0;
      if (mem_rd_en) begin
        rnd <= int'($urandom_range(4, 1));
        pa <= mem_addr;
        if (lat_use == 1) begin
          mem_rd_valid <= 1;
          mem_rd_data <= 16'h0100 + {6'b0, mem_addr};
        end else cnt <= lat_use - 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          mem_rd_valid <= 1;
          mem_rd_data <= 16'h0100 + {6'b0, pa};
        end
      end
    end
  end

  always @(posedge clk) begin
    if (read_done) n_done <= n_done + 1;
    if (last_sample && !read_done) n_stray <= n_stray + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_next();
    exp_t e;
    for (int j = 0; j < 6; j++) e.d[j*16 +: 16] = 16'h0100 + 16'(nxt_s * 7 + j);
    e.t = 3'(16'h0100 + 16'(nxt_s * 7 + 6));
    e.l = nxt_s == 63;
    q.push_back(e);
    nxt_s = (nxt_s + 1) % 64;
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s read_done with empty scoreboard", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_data"}, training_data, e.d);
      chk({tag, "_type"}, training_data_type, e.t);
      chk({tag, "_last"}, last_sample, e.l);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!read_done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, read_done, 1);
    if (read_done) check_pop(tag);
  endtask

  task automatic wait_rd(input string tag, input int a);
    int k = 0;
    while (!mem_rd_en && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rd_en"}, mem_rd_en, 1);
    chk({tag, "_addr"}, mem_addr, a);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_read_done", read_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", training_data, 0);
    chk("rst_type", training_data_type, 0);
    chk("rst_last", last_sample, 0);
    rst = 0;
    @(negedge clk);
    // single fetch, latency 1, exact cycle timing
    lat_sel = 1;
    data_request = 1;
    push_next();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) data_request = 0;
      chk($sformatf("single_rd_en_%0d", k), mem_rd_en, (k % 2 == 1 && k <= 13));
      if (k % 2 == 1 && k <= 13) chk($sformatf("single_addr_%0d", k), mem_addr, (k - 1) / 2);
      chk($sformatf("single_done_%0d", k), read_done, k == 15);
      if (k == 15) check_pop("single");
    end
    @(negedge clk);
    chk("single_idle", busy, 0);
    chk("single_hold", training_data, 96'h0105_0104_0103_0102_0101_0100);
    chk("single_hold_type", training_data_type, 3'h6);
    // reset mid-fetch
    lat_sel = 3;
    data_request = 1;
    @(negedge clk);
    data_request = 0;
    chk("rstmid_addr_before", mem_addr, 7);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_data", training_data, 0);
    chk("rstmid_type", training_data_type, 0);
    chk("rstmid_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    nxt_s = 0;
    @(negedge clk);
    data_request = 1;
    push_next();
    @(negedge clk);
    data_request = 0;
    wait_rd("rstmid_first", 0);
    wait_done("rstmid_fetch");
    @(negedge clk);
    // continuous request over a full epoch with random latency
    restart = 1;
    @(negedge clk);
    restart = 0;
    nxt_s = 0;
    lat_sel = 0;
    for (int i = 0; i < 65; i++) push_next();
    data_request = 1;
    for (int i = 0; i < 65; i++) begin
      wait_done($sformatf("epoch_%0d", i));
      if (i == 64) data_request = 0;
      @(negedge clk);
      if (i == 63) wait_rd("wrap", 0);
    end
    chk("no_stray_last", n_stray, 0);
    // request while busy: one pending, further pulses merged
    lat_sel = 1;
    repeat (3) @(negedge clk);
    saved_done = n_done;
    data_request = 1;
    push_next();
    @(negedge clk);
    data_request = 0;
    repeat (2) @(negedge clk);
    data_request = 1;
    push_next();
    @(negedge clk);
    data_request = 0;
    repeat (2) @(negedge clk);
    data_request = 1;
    @(negedge clk);
    data_request = 0;
    wait_done("pend_first");
    @(negedge clk);
    wait_done("pend_second");
    repeat (40) @(negedge clk);
    chk("pend_count", n_done - saved_done, 2);
    chk("pend_idle", busy, 0);
    // restart during WAIT with the return three cycles out
    lat_sel = 4;
    held = training_data;
    saved_done = n_done;
    data_request = 1;
    @(negedge clk);
    data_request = 0;
    chk("drain_rd_en", mem_rd_en, 1);
    chk("drain_addr", mem_addr, nxt_s * 7);
    @(negedge clk);
    restart = 1;
    @(negedge clk);
    restart = 0;
    chk("drain_busy", busy, 1);
    repeat (4) @(negedge clk);
    chk("drain_idle", busy, 0);
    chk("drain_hold", training_data, held);
    chk("drain_no_done", n_done, saved_done);
    nxt_s = 0;
    lat_sel = 1;
    data_request = 1;
    push_next();
    @(negedge clk);
    data_request = 0;
    wait_rd("drain_next", 0);
    wait_done("drain_next");
    @(negedge clk);
    // restart coincident with PRESENT
    held = training_data;
    saved_done = n_done;
    data_request = 1;
    @(negedge clk);
    data_request = 0;
    repeat (14) @(negedge clk);
    restart = 1;
    #1;
    chk("rp_busy", busy, 1);
    chk("rp_no_done", read_done, 0);
    chk("rp_no_last", last_sample, 0);
    @(negedge clk);
    restart = 0;
    chk("rp_idle", busy, 0);
    chk("rp_hold", training_data, held);
    chk("rp_done_count", n_done, saved_done);
    nxt_s = 0;
    data_request = 1;
    push_next();
    @(negedge clk);
    data_request = 0;
    wait_rd("rp_next", 0);
    wait_done("rp_next");
    repeat (2) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/training_data_fetcher.md
Name: training_data_fetcher

Overview:
- Upstream stage of the distance calculator in the KNN datapath.
- On each data_request it fetches one training sample from word-serial training memory: M*N feature words plus one type word.
- It assembles the sample into the packed training_data vector with its training_data_type, then pulses read_done.
- It walks NUM_SAMPLES samples, flags the last one, then wraps to BASE_ADDR for the next inference epoch.

Parameters:
- M, 2, feature matrix rows
- N, 3, feature matrix columns
- W, 16, feature word width in bits
- TYPE_W, 3, class-type width in bits
- NUM_SAMPLES, 64, samples per epoch; equals 1<<L of the sort stage
- ADDR_W, 10, memory address width
- BASE_ADDR, 0, address of word 0 of sample 0

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- data_request  in  1  level; next sample wanted
- restart  in  1  one-cycle pulse; abort and rewind to sample 0
- mem_rd_en  out  1  one-cycle read strobe
- mem_addr  out  ADDR_W  read address, valid with mem_rd_en
- mem_rd_data  in  W  returned word
- mem_rd_valid  in  1  mem_rd_data valid; latency ≥1 cycle, one outstanding read
- training_data  out  W*M*N  packed sample; word j at [(j+1)*W-1 -: W]
- training_data_type  out  TYPE_W  class of presented sample
- read_done  out  1  one-cycle pulse; sample outputs updated
- last_sample  out  1  high with read_done for sample NUM_SAMPLES-1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async) values:
  - read_done, last_sample, busy, mem_rd_en = 0; mem_addr = BASE_ADDR.
  - training_data and training_data_type = 0; sample counter = 0; word counter = 0.
  - State = IDLE; pending = 0.
- Memory layout: sample s occupies M*N+1 consecutive words from BASE_ADDR + s*(M*N+1).
  - Words 0..M*N-1 are features; word M*N holds the type in bits [TYPE_W-1:0], upper bits ignored.
  - The address comes from a running counter; no multiplier.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, DRAIN.
  - IDLE: if data_request or pending is high, go to ISSUE and clear pending.
  - ISSUE: assert mem_rd_en for exactly one cycle with the current address, then go to WAIT.
  - WAIT: on mem_rd_valid, write the word into the shadow assembly register at slot word_cnt, or into the shadow type register if word_cnt = M*N.
    - If more words remain: increment address and word_cnt, go to ISSUE.
    - Otherwise go to PRESENT.
  - PRESENT (1 cycle):
    - Copy shadow registers to the outputs and pulse read_done.
    - last_sample = (sample_cnt == NUM_SAMPLES-1).
    - Increment sample_cnt; at NUM_SAMPLES-1 it wraps to 0 and the address wraps to BASE_ADDR.
    - Clear word_cnt; go to IDLE.
- Outputs change only in PRESENT and stay stable between read_done pulses; partial fetches are never visible.
- Latency: with memory latency R, data_request sampled in IDLE at cycle t gives read_done at t + (M*N+1)*(R+1) + 1.
  - With defaults and R=1: t+15.
- data_request is level-sensitive and may stay high; each IDLE visit starts one fetch.
- A request rising while busy sets pending, single-depth; further requests while pending is set are merged.
- mem_rd_valid outside WAIT/DRAIN is ignored.
- restart, highest priority, any state:
  - Clears sample_cnt, word_cnt and pending; sets address to BASE_ADDR.
  - Output data registers are held; read_done and last_sample are forced to 0 that cycle.
  - From WAIT, or from ISSUE (read already in flight), go to DRAIN; otherwise go to IDLE.
  - DRAIN discards the next mem_rd_valid, then goes to IDLE.
- restart coincident with PRESENT: the read_done pulse is suppressed.
- Counters are sized as clog2(NUM_SAMPLES) and clog2(M*N+1) bits; the address wraps modulo 2^ADDR_W with no error.

Decomposition:
- Shared package knn_pkg holds:
  - the default M, N, W, TYPE_W and L, with NUM_SAMPLES = 1<<L;
  - localparam SAMPLE_WORDS = M*N+1;
  - the fetch-state enum (IDLE, ISSUE, WAIT, PRESENT, DRAIN).
- Single module, no sub-module; shadow registers and the FSM fit comfortably in one unit.

Test Plan:
- Reset mid-fetch: assert rst during WAIT.
  - Outputs go to 0 and mem_addr to BASE_ADDR immediately.
  - The first request after release reads address 0.
- Single fetch, latency 1, memory word a = 16'h0100+a:
  - Request at t gives mem_rd_en at t+1, t+3, …, t+13 and read_done at t+15.
  - training_data word j = 16'h0100+j; type = 3'h6 (low bits of 16'h0106).
- Continuous data_request for 64 samples with variable latency 1–4:
  - 64 read_done pulses; last_sample only on the 64th.
  - The 65th fetch reads from address 0 again.
- Request while busy: pulse data_request again mid-fetch.
  - Exactly one extra fetch follows the first read_done; a third pulse in the same window is merged.
- restart during WAIT with the return due 3 cycles later:
  - The late word is discarded and outputs are unchanged.
  - The next fetch returns sample 0 data.
- restart coincident with PRESENT:
  - No read_done; sample_cnt = 0; the next sample presented is sample 0.
